// File: rtl/phy_read_mode.sv
// PHY read capture path: waits read latency, captures one DQS-strobed burst into a local FIFO,
// then drains it to the Read Buffer over valid/ready, reporting ACK or DQS timeout.
module phy_read_mode #(
    parameter int unsigned MEM_DATAWIDTH = 64,
    parameter int unsigned BURST_LENGTH  = 8,
    parameter int unsigned READ_LATENCY  = 16,
    parameter int unsigned DQS_TIMEOUT   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dqs_t,
    input  logic                     dqs_c,
    input  logic [MEM_DATAWIDTH-1:0] indata,
    input  logic                     rdStart,
    output logic                     rdBusy,
    output logic [MEM_DATAWIDTH-1:0] outData,
    output logic                     outValid,
    input  logic                     outReady,
    output logic                     outLast,
    output logic                     outACK,
    output logic                     rdErr,
    output logic                     ReadModeDQSValid
);

    localparam int unsigned PtrW  = $clog2(BURST_LENGTH);
    localparam int unsigned LatW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int unsigned IdleW = (DQS_TIMEOUT > 1) ? $clog2(DQS_TIMEOUT) : 1;

    localparam logic [PtrW-1:0]  LastPtr  = PtrW'(BURST_LENGTH - 1);
    localparam logic [LatW-1:0]  LatInit  = LatW'(READ_LATENCY - 1);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(DQS_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StWaitCl, StArm, StCapture, StDrain} state_e;

    state_e                   state_q;
    logic [LatW-1:0]          lat_cnt_q;
    logic [IdleW-1:0]         idle_cnt_q;
    logic [PtrW-1:0]          wr_ptr_q;
    logic [PtrW-1:0]          rd_ptr_q;
    logic                     dqs_t_q;
    logic                     ack_q;
    logic                     err_q;
    logic [MEM_DATAWIDTH-1:0] fifo_q [BURST_LENGTH];

    logic dqs_edge;
    logic window;
    logic capture_en;

    // A beat needs a true-strobe transition with a properly complementary dqs_c.
    assign dqs_edge   = (dqs_t != dqs_t_q) && (dqs_c == ~dqs_t);
    assign window     = (state_q == StArm) || (state_q == StCapture);
    assign capture_en = dqs_edge && window;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            lat_cnt_q  <= '0;
            idle_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            dqs_t_q    <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            dqs_t_q <= dqs_t;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rdStart) begin
                        state_q    <= StWaitCl;
                        lat_cnt_q  <= LatInit;
                        idle_cnt_q <= '0;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                    end
                end
                StWaitCl: begin
                    if (lat_cnt_q == '0) begin
                        state_q    <= StArm;
                        idle_cnt_q <= '0;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                StArm, StCapture: begin
                    // wr_ptr_q is 0 in ARM, so the first beat lands in fifo[0].
                    if (dqs_edge) begin
                        idle_cnt_q <= '0;
                        if (wr_ptr_q == LastPtr) begin
                            state_q  <= StDrain;
                            rd_ptr_q <= '0;
                        end else begin
                            state_q  <= StCapture;
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end else if (idle_cnt_q == IdleLast) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (outReady) begin
                        if (rd_ptr_q == LastPtr) begin
                            ack_q   <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Storage is not reset; stale contents are never exposed because outData is gated by outValid.
    always_ff @(posedge clk) begin
        if (!rst && capture_en) begin
            fifo_q[wr_ptr_q] <= indata;
        end
    end

    assign rdBusy           = (state_q != StIdle);
    assign outValid         = (state_q == StDrain);
    assign outLast          = outValid && (rd_ptr_q == LastPtr);
    assign outData          = outValid ? fifo_q[rd_ptr_q] : '0;
    assign outACK           = ack_q;
    assign rdErr            = err_q;
    assign ReadModeDQSValid = window;

endmodule

// File: tb/tb_phy_read_mode.sv
// Randomized bench for phy_read_mode, checked every cycle against a transaction-level model
// plus a burst scoreboard of delivered beats.
module tb_phy_read_mode;

    localparam int W  = 64;
    localparam int BL = 8;
    localparam int L  = 16;
    localparam int T  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         dqs_t = 1'b0;
    logic         dqs_c = 1'b1;
    logic [W-1:0] indata = '0;
    logic         rdStart = 1'b0;
    logic         outReady = 1'b1;
    logic         rdBusy, outValid, outLast, outACK, rdErr, ReadModeDQSValid;
    logic [W-1:0] outData;

    phy_read_mode #(
        .MEM_DATAWIDTH(W),
        .BURST_LENGTH (BL),
        .READ_LATENCY (L),
        .DQS_TIMEOUT  (T)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .dqs_t           (dqs_t),
        .dqs_c           (dqs_c),
        .indata          (indata),
        .rdStart         (rdStart),
        .rdBusy          (rdBusy),
        .outData         (outData),
        .outValid        (outValid),
        .outReady        (outReady),
        .outLast         (outLast),
        .outACK          (outACK),
        .rdErr           (rdErr),
        .ReadModeDQSValid(ReadModeDQSValid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ack_cnt  = 0;
    int err_cnt  = 0;
    logic [W-1:0] got_q[$];

    // Reference: a read is "busy" from acceptance; the strobe window opens L+1 cycles later;
    // the burst is complete once BL beats are held; T quiet window cycles abort it.
    bit           m_busy = 0;
    int           m_age = 0, m_quiet = 0, m_rd = 0;
    logic [W-1:0] m_beats[$];
    bit           m_ack = 0, m_err = 0;
    logic         m_prev_t = 1'b0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit e;
        e = (dqs_t != m_prev_t) && (dqs_c == ~dqs_t);
        m_ack = 0;
        m_err = 0;
        if (rst) begin
            m_busy   = 0;
            m_prev_t = 1'b0;
            m_beats.delete();
        end else begin
            m_prev_t = dqs_t;
            if (!m_busy) begin
                if (rdStart) begin
                    m_busy  = 1;
                    m_age   = 0;
                    m_quiet = 0;
                    m_rd    = 0;
                    m_beats.delete();
                end
            end else if (m_beats.size() == BL) begin
                if (outReady) begin
                    m_rd++;
                    if (m_rd == BL) begin
                        m_busy = 0;
                        m_ack  = 1;
                    end
                end
            end else begin
                m_age++;
                if (m_age > L) begin
                    if (e) begin
                        m_beats.push_back(indata);
                        m_quiet = 0;
                    end else begin
                        m_quiet++;
                        if (m_quiet == T) begin
                            m_busy = 0;
                            m_err  = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        bit           ev;
        logic [W-1:0] ed;
        if (outValid && outReady && !rst) got_q.push_back(outData);
        model_step();
        @(posedge clk);
        #1;
        if (outACK) ack_cnt++;
        if (rdErr) err_cnt++;
        ev = m_busy && (m_beats.size() == BL);
        ed = ev ? m_beats[m_rd] : '0;
        check_eq("rdBusy", W'(rdBusy), W'(m_busy));
        check_eq("outValid", W'(outValid), W'(ev));
        check_eq("outLast", W'(outLast), W'(ev && (m_rd == BL - 1)));
        check_eq("outData", outData, ed);
        check_eq("outACK", W'(outACK), W'(m_ack));
        check_eq("rdErr", W'(rdErr), W'(m_err));
        check_eq("dqsValid", W'(ReadModeDQSValid),
                 W'(m_busy && (m_beats.size() < BL) && (m_age >= L)));
    endtask

    task automatic start_read(input bit noise, input bit extra);
        rdStart = 1'b1;
        tick();
        rdStart = 1'b0;
        for (int i = 0; i < L; i++) begin
            if (noise && $urandom_range(0, 1) == 1) begin
                dqs_t = ~dqs_t;
                dqs_c = ~dqs_t;
            end
            if (extra && i == L / 2) rdStart = 1'b1;
            tick();
            rdStart = 1'b0;
        end
    endtask

    task automatic send_beats(input logic [W-1:0] base, input int n, input bit glitch,
                              input int rst_at);
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = glitch ? int'($urandom_range(0, T - 1)) : 0;
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 1) == 1) begin
                    dqs_t = ~dqs_t;
                    dqs_c = dqs_t;
                end else begin
                    dqs_c = ~dqs_t;
                end
                indata = {$urandom, $urandom};
                tick();
            end
            dqs_t  = ~dqs_t;
            dqs_c  = ~dqs_t;
            indata = base + W'(i);
            if (i == rst_at) rst = 1'b1;
            tick();
            if (i == rst_at) begin
                rst = 1'b0;
                return;
            end
        end
        dqs_c = ~dqs_t;
    endtask

    // mode 0: always ready; 1: 3-cycle stalls at beats 2 and 7; 2: random ready + stray rdStart
    task automatic drain(input int mode, input int rst_at, input logic [W-1:0] base);
        int sb0, a0, n, stall_n, stalled, budget;
        bit done;
        sb0 = got_q.size();
        a0 = ack_cnt;
        stall_n = -1;
        stalled = 0;
        done = 0;
        budget = 0;
        while (!done && budget < 200) begin
            n = got_q.size() - sb0;
            if (rst_at >= 0 && n == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                return;
            end
            if (n != stall_n) begin
                stall_n = n;
                stalled = 0;
            end
            outReady = 1'b1;
            if (mode == 1 && (n == 2 || n == 7) && stalled < 3) begin
                outReady = 1'b0;
                stalled++;
            end
            if (mode == 2) begin
                outReady = ($urandom_range(0, 3) != 0);
                rdStart  = ($urandom_range(0, 4) == 0);
            end
            tick();
            rdStart = 1'b0;
            done = outACK;
            budget++;
        end
        outReady = 1'b1;
        check_eq("drain_done", W'(done), W'(1));
        check_eq("ack_count", W'(ack_cnt - a0), W'(1));
        check_eq("beat_count", W'(got_q.size() - sb0), W'(BL));
        for (int i = 0; i < BL && sb0 + i < got_q.size(); i++) begin
            check_eq("beat_data", got_q[sb0 + i], base + W'(i));
        end
    endtask

    task automatic wait_err();
        int n, a0, g0;
        n = 0;
        a0 = ack_cnt;
        g0 = got_q.size();
        while (!rdErr && n < 50) begin
            tick();
            n++;
        end
        check_eq("err_delay", W'(n), W'(T));
        check_eq("err_noack", W'(ack_cnt - a0), W'(0));
        check_eq("err_nodata", W'(got_q.size() - g0), W'(0));
        tick();
    endtask

    task automatic nominal(input logic [W-1:0] base);
        start_read(0, 0);
        send_beats(base, BL, 0, -1);
        drain(0, -1, base);
    endtask

    initial begin
        int a0, e0;
        logic [W-1:0] b;
        tick();
        tick();
        rst = 1'b0;
        tick();

        nominal(64'h1000);
        tick();

        start_read(0, 0);
        send_beats(64'h1000, BL, 0, -1);
        drain(1, -1, 64'h1000);
        tick();

        start_read(0, 0);
        wait_err();
        start_read(0, 0);
        send_beats(64'h3000, 5, 0, -1);
        wait_err();

        start_read(1, 1);
        send_beats(64'h4000, BL, 1, -1);
        drain(2, -1, 64'h4000);
        tick();

        a0 = ack_cnt;
        e0 = err_cnt;
        start_read(0, 0);
        send_beats(64'h5000, BL, 0, 4);
        tick();
        start_read(0, 0);
        send_beats(64'h5100, BL, 0, -1);
        drain(0, 3, 64'h5100);
        tick();
        tick();
        check_eq("rst_noack", W'(ack_cnt - a0), W'(0));
        check_eq("rst_noerr", W'(err_cnt - e0), W'(0));
        nominal(64'h1000);

        a0 = ack_cnt;
        nominal(64'h1000);
        nominal(64'h2000);
        check_eq("b2b_acks", W'(ack_cnt - a0), W'(2));

        for (int k = 0; k < 8; k++) begin
            b = {$urandom, $urandom};
            start_read($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                send_beats(b, int'($urandom_range(0, BL - 1)), $urandom_range(0, 1) == 1, -1);
                wait_err();
            end else begin
                send_beats(b, BL, $urandom_range(0, 1) == 1, -1);
                drain(($urandom_range(0, 1) == 1) ? 2 : 1, -1, b);
            end
        end
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/phy_read_mode.md
Name: phy_read_mode

Overview:
PHY-side READ data capture path inside the PHYController. It is the receive-direction counterpart of the PHY write datapath.
- After the controller issues a READ, it waits the read latency, then captures one burst of DQ beats strobed by DQS transitions.
- It buffers the burst in a PHY-local FIFO, then drains it to the Read Buffer over a valid/ready handshake.
- It signals burst completion, or a DQS-timeout error, back to the PHYController.

Parameters:
MEM_DATAWIDTH, 64, DQ bus width in bits
BURST_LENGTH, 8, beats per burst (power of two, >=2)
READ_LATENCY, 16, clk cycles from accepted rdStart to capture-window open (>=1)
DQS_TIMEOUT, 4, max clk cycles without a DQS edge while armed or capturing (>=1)

Ports:
clk  in  1  sole clock; every register is clocked on its rising edge
rst  in  1  synchronous, active-high reset
dqs_t  in  1  DQS true from DRAM
dqs_c  in  1  DQS complement from DRAM
indata  in  MEM_DATAWIDTH  DQ bus from DRAM
rdStart  in  1  PHYController READ-issued pulse; accepted only in IDLE
rdBusy  out  1  high whenever state != IDLE
outData  out  MEM_DATAWIDTH  beat toward Read Buffer
outValid  out  1  outData valid
outReady  in  1  Read Buffer accepts the beat
outLast  out  1  marks final beat of the burst (qualified by outValid)
outACK  out  1  one-cycle pulse, once per completed burst
rdErr  out  1  one-cycle pulse on DQS timeout
ReadModeDQSValid  out  1  high while in ARM or CAPTURE

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; all counters and pointers = 0; dqs_t_d = 0.
  - Outputs: rdBusy, outValid, outLast, outACK, rdErr, ReadModeDQSValid = 0; outData = 0.
  - Applies mid-operation: any partial burst is discarded and no ACK or error is issued. FIFO contents are don't-care after reset.
- Beat strobe: edge = (dqs_t != dqs_t_d) && (dqs_c == ~dqs_t). dqs_t_d is dqs_t registered every cycle. A beat is captured from indata in the same cycle edge is high.
- FSM states: IDLE, WAIT_CL, ARM, CAPTURE, DRAIN.
- IDLE:
  - rdStart=1 -> WAIT_CL, lat_cnt = READ_LATENCY-1.
  - rdStart in any other state is ignored; no queuing.
- WAIT_CL:
  - lat_cnt decrements each cycle.
  - When lat_cnt==0 -> ARM, idle_cnt = 0.
  - Edges seen in WAIT_CL are ignored.
- ARM:
  - edge -> write fifo[0] = indata, wr_ptr = 1, idle_cnt = 0, go to CAPTURE.
  - Otherwise idle_cnt++.
  - If idle_cnt reaches DQS_TIMEOUT-1 with no edge -> pulse rdErr, go to IDLE.
- CAPTURE:
  - edge -> fifo[wr_ptr] = indata, idle_cnt = 0.
  - If wr_ptr == BURST_LENGTH-1 -> DRAIN with rd_ptr = 0; otherwise wr_ptr++.
  - No edge -> idle_cnt++. Timeout is handled as in ARM: rdErr pulse, IDLE, burst discarded, outValid never raised.
- DRAIN:
  - outValid = 1, outData = fifo[rd_ptr], outLast = (rd_ptr == BURST_LENGTH-1).
  - A transfer occurs when outValid && outReady.
  - outData, outValid and outLast stay stable while outReady = 0. There is no backpressure limit.
  - A transfer with outLast -> outACK = 1 on the next cycle, state=IDLE, outValid = 0.
  - A new rdStart is accepted in the same cycle outACK is high, since the state is IDLE then.
- outData is driven combinationally from the FIFO read port. It is 0 when outValid = 0.
- Pointer widths: $clog2(BURST_LENGTH). Pointers never wrap within a burst; they reset to 0 per burst.
- DQS edges outside ARM/CAPTURE (IDLE, WAIT_CL, DRAIN) are ignored; extra postamble toggles do not corrupt the FIFO.
- Exactly one of outACK or rdErr fires per accepted rdStart, except when reset intervenes.

Test Plan:
1. Nominal burst:
   - Stimulus: rdStart at cycle 0; DQS toggles every cycle from cycle 16; indata = 0x1000+i on beat i; outReady = 1.
   - Required response: outData 0x1000..0x1007 in order on consecutive cycles; outLast on the 8th beat; outACK exactly 1 cycle after it; rdBusy low the following cycle.
2. Backpressure:
   - Stimulus: as test 1, with outReady low for 3 cycles at beats 2 and 7.
   - Required response: outData and outLast held stable while stalled; all 8 beats delivered once; single outACK.
3. DQS timeout:
   - Stimulus: rdStart with no DQS toggles.
   - Required response: rdErr pulse at cycle READ_LATENCY+DQS_TIMEOUT; no outValid; no outACK; IDLE afterwards.
   - Stimulus: repeat with DQS stopping after 5 beats.
   - Required response: rdErr after 4 idle cycles; no data delivered.
4. Ignored and invalid strobes:
   - Stimulus: rdStart pulsed during WAIT_CL and during DRAIN; DQS toggling during WAIT_CL; dqs_c == dqs_t glitches during CAPTURE.
   - Required response: no second burst; glitches not counted as beats; captured data exact.
5. Reset mid-operation:
   - Stimulus: rst=1 for 1 cycle at CAPTURE beat 4, then at DRAIN beat 3.
   - Required response: all outputs 0 the next cycle; no outACK/rdErr; a subsequent nominal burst succeeds.
6. Back-to-back:
   - Stimulus: rdStart in the cycle outACK=1.
   - Required response: second burst 0x2000..0x2007 captured and delivered correctly; two outACK pulses total.
